// File: rtl/core_pkg.sv
// Shared types and request-decode helpers for the core load/store unit.
package core_pkg;

    typedef enum logic [2:0] {
        SIZE_B  = 3'd0,
        SIZE_BU = 3'd1,
        SIZE_H  = 3'd2,
        SIZE_HU = 3'd3,
        SIZE_W  = 3'd4
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SIZE_W:          return off != 2'b00;
            SIZE_H, SIZE_HU: return off[0];
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input mem_size_e size, input logic [1:0] off);
        case (size)
            SIZE_B, SIZE_BU: return 4'b0001 << off;
            SIZE_H, SIZE_HU: return 4'b0011 << off;
            default:         return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data across every lane it may land on.
    function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] wdata);
        case (size)
            SIZE_B, SIZE_BU: return {4{wdata[7:0]}};
            SIZE_H, SIZE_HU: return {2{wdata[15:0]}};
            default:         return wdata;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational load aligner: picks the addressed byte/half out of the bus
// word and sign- or zero-extends it according to the access size.
module core_lsu_align
    import core_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  off,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = bus_rdata >> {off, 3'b000};
        case (size)
            SIZE_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            SIZE_BU: load_data = {24'h0, shifted[7:0]};
            SIZE_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            SIZE_HU: load_data = {16'h0, shifted[15:0]};
            default: load_data = bus_rdata;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Single-outstanding load/store unit: IDLE -> BUS -> RESP, with misaligned
// requests short-circuiting to RESP. Bus timeout fault enabled by CORE_LSU_TIMEOUT_EN.
module core_lsu
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // Request handshake: a request transfers on any rising edge where
    // req_valid && req_ready; req_ready is high only while IDLE.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  mem_size_e   req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output lsu_state_e  dbg_state
);

    lsu_state_e  state;
    mem_size_e   size_q;
    logic [1:0]  off_q;
    logic [29:0] word_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic        fault_q;
    logic [31:0] load_data;
    logic        timeout;
    logic        in_bus;
    logic        in_resp;

    assign in_bus  = (state == BUS);
    assign in_resp = (state == RESP);

    core_lsu_align u_align (
        .size      (size_q),
        .off       (off_q),
        .bus_rdata (bus_rdata),
        .load_data (load_data)
    );

`ifdef CORE_LSU_TIMEOUT_EN
    logic [31:0] wait_cnt;

    // Held at zero outside BUS, so it is already clear on every BUS entry.
    always_ff @(posedge clk) begin
        if (rst || !in_bus) begin
            wait_cnt <= '0;
        end else if (!bus_ack && !bus_err) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign timeout = in_bus && !bus_ack && !bus_err
                     && (wait_cnt == (32'(TIMEOUT_CYCLES) - 32'd1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            size_q  <= SIZE_B;
            off_q   <= 2'b00;
            word_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        word_q  <= req_addr[31:2];
                        we_q    <= req_write;
                        wstrb_q <= req_write ? store_strobe(req_size, req_addr[1:0]) : 4'b0000;
                        wdata_q <= req_write ? store_lanes(req_size, req_wdata) : 32'h0;
                        rdata_q <= '0;
                        fault_q <= 1'b0;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            mis_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            mis_q <= 1'b0;
                            state <= BUS;
                        end
                    end
                end
                BUS: begin
                    // Error outranks a simultaneous ack.
                    if (bus_err || timeout) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                        state   <= RESP;
                    end else if (bus_ack) begin
                        rdata_q <= we_q ? 32'h0 : load_data;
                        state   <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state == IDLE);
    assign bus_req        = in_bus;
    assign bus_we         = in_bus && we_q;
    assign bus_addr       = in_bus ? {word_q, 2'b00} : 32'h0;
    assign bus_wstrb      = in_bus ? wstrb_q : 4'b0000;
    assign bus_wdata      = in_bus ? wdata_q : 32'h0;
    assign rsp_valid      = in_resp;
    assign rsp_rdata      = in_resp ? rdata_q : 32'h0;
    assign rsp_misaligned = in_resp && mis_q;
    assign rsp_fault      = in_resp && fault_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed scenarios plus a randomized
// scoreboard run. Timeout scenario depends on CORE_LSU_TIMEOUT_EN.
module tb_core_lsu;
    import core_pkg::*;

    localparam int W = 34;  // {misaligned, fault, rdata}

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    mem_size_e   req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_misaligned, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    lsu_state_e  dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    core_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_mis(input mem_size_e sz, input logic [1:0] off);
        if (sz == SIZE_W) return off != 2'd0;
        if (sz == SIZE_H || sz == SIZE_HU) return off == 2'd1 || off == 2'd3;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_strobe(input logic wr, input mem_size_e sz, input logic [1:0] off);
        logic [3:0] byte_tab [4];
        logic [3:0] half_tab [4];
        byte_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        half_tab = '{4'b0011, 4'b0110, 4'b1100, 4'b1000};
        if (!wr) return 4'b0000;
        if (sz == SIZE_B || sz == SIZE_BU) return byte_tab[off];
        if (sz == SIZE_H || sz == SIZE_HU) return half_tab[off];
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic wr, input mem_size_e sz, input logic [31:0] d);
        if (!wr) return 32'h0;
        if (sz == SIZE_B || sz == SIZE_BU) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == SIZE_H || sz == SIZE_HU) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input mem_size_e sz, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = (off == 2'd2) ? w[31:16] : w[15:0];
        case (sz)
            SIZE_B:  return 32'($signed(b));
            SIZE_BU: return {24'h0, b};
            SIZE_H:  return 32'($signed(h));
            SIZE_HU: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic wr, input mem_size_e sz, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_checks++; if ({rsp_valid, rsp_misaligned, rsp_fault, rsp_rdata} !== 35'h0) begin
            n_fail++; $display("FAIL reset_rsp: got %b%b%b %h want all 0", rsp_valid, rsp_misaligned, rsp_fault, rsp_rdata); end
        n_checks++; if ({bus_we, bus_wstrb, bus_addr, bus_wdata} !== 69'h0) begin
            n_fail++; $display("FAIL reset_bus_out: got we=%b strb=%b addr=%h wdata=%h want 0", bus_we, bus_wstrb, bus_addr, bus_wdata); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_byte_signed();
        logic [W-1:0] exp;
        exp_q.push_back({1'b0, 1'b0, 32'hFFFF_FF80});
        send(1'b0, SIZE_B, 32'h0000_0103, 32'h0);
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL lb_bus_req: got %b want 1", bus_req); end
        n_checks++; if (bus_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h want 00000100", bus_addr); end
        n_checks++; if ({bus_we, bus_wstrb} !== 5'b0) begin n_fail++; $display("FAIL lb_we_strb: got %b/%b want 0/0000", bus_we, bus_wstrb); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lb_early_rsp: got %b want 0", rsp_valid); end
        bus_rdata = 32'h80FF_FF00;
        bus_ack   = 1'b1;
        tick();
        bus_ack   = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL lb_latency: rsp_valid got %b want 1 at N+2", rsp_valid);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_misaligned, rsp_fault, rsp_rdata} !== exp) begin
                n_fail++; $display("FAIL lb_rsp: got %h want %h", {rsp_misaligned, rsp_fault, rsp_rdata}, exp); end
        end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL lb_after: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_store_half();
        logic [W-1:0] exp;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        send(1'b1, SIZE_H, 32'h0000_0202, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wstrb !== 4'b1100 ||
                bus_wdata !== 32'hBEEF_BEEF || bus_addr !== 32'h200) begin
                n_fail++; $display("FAIL sh_bus[%0d]: got req=%b we=%b strb=%b wdata=%h addr=%h want 1 1 1100 beefbeef 00000200",
                                   i, bus_req, bus_we, bus_wstrb, bus_wdata, bus_addr);
            end
            if (i < 2) tick();
        end
        bus_rdata = 32'hDEAD_0000;
        bus_ack   = 1'b1;
        tick();
        bus_ack   = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL sh_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_misaligned, rsp_fault, rsp_rdata} !== exp) begin
                n_fail++; $display("FAIL sh_rsp: got %h want %h", {rsp_misaligned, rsp_fault, rsp_rdata}, exp); end
        end
        tick();
    endtask

    task automatic test_misaligned();
        logic [W-1:0] exp;
        mem_size_e    sizes [2];
        logic [31:0]  addrs [2];
        sizes = '{SIZE_W, SIZE_HU};
        addrs = '{32'h0000_0301, 32'h0000_0203};
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b1, 1'b0, 32'h0});
            send(k == 1, sizes[k], addrs[k], 32'h1234_5678);
            n_checks++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL mis_latency[%0d]: rsp_valid got %b want 1 at N+1", k, rsp_valid);
            end else begin
                exp = exp_q.pop_front();
                if ({rsp_misaligned, rsp_fault, rsp_rdata} !== exp) begin
                    n_fail++; $display("FAIL mis_rsp[%0d]: got %h want %h", k, {rsp_misaligned, rsp_fault, rsp_rdata}, exp); end
            end
            n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_bus_req[%0d]: got %b want 0", k, bus_req); end
            tick();
            n_checks++; if (bus_req !== 1'b0 || rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL mis_after[%0d]: bus_req=%b rsp_valid=%b want 0/0", k, bus_req, rsp_valid); end
        end
    endtask

    task automatic test_ack_err();
        logic [W-1:0] exp;
        // Stray completion while idle must be ignored.
        bus_ack = 1'b1;
        bus_err = 1'b1;
        tick();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_ack_ignored: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        send(1'b0, SIZE_HU, 32'h0000_0400, 32'h0);
        bus_rdata = 32'h1234_5678;
        bus_ack   = 1'b1;
        bus_err   = 1'b1;
        tick();
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL ackerr_valid: got %b want 1", rsp_valid);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_misaligned, rsp_fault, rsp_rdata} !== exp) begin
                n_fail++; $display("FAIL ackerr_rsp: got %h want %h", {rsp_misaligned, rsp_fault, rsp_rdata}, exp); end
        end
        tick();
    endtask

    task automatic test_timeout();
        int bus_cycles = 0;
        logic [W-1:0] exp;
        send(1'b0, SIZE_W, 32'h0000_0500, 32'h0);
`ifdef CORE_LSU_TIMEOUT_EN
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        while (bus_req === 1'b1 && bus_cycles < 50) begin
            bus_cycles++;
            tick();
        end
        n_checks++; if (bus_cycles != 4) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 4", bus_cycles); end
        n_checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL timeout_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_misaligned, rsp_fault, rsp_rdata} !== exp) begin
                n_fail++; $display("FAIL timeout_rsp: got %h want %h", {rsp_misaligned, rsp_fault, rsp_rdata}, exp); end
        end
`else
        exp_q.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
        while (bus_req === 1'b1 && bus_cycles < 40) begin
            bus_cycles++;
            tick();
        end
        n_checks++; if (bus_cycles != 40) begin n_fail++; $display("FAIL wait_forever: bus_req held %0d cycles want 40", bus_cycles); end
        bus_rdata = 32'hCAFE_F00D;
        bus_ack   = 1'b1;
        tick();
        bus_ack   = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL wait_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_misaligned, rsp_fault, rsp_rdata} !== exp) begin
                n_fail++; $display("FAIL wait_rsp: got %h want %h", {rsp_misaligned, rsp_fault, rsp_rdata}, exp); end
        end
`endif
        tick();
    endtask

    task automatic test_reset_in_bus();
        send(1'b0, SIZE_W, 32'h0000_0600, 32'h0);
        tick();
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstbus_pre: bus_req got %b want 1", bus_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstbus_abort: bus_req=%b req_ready=%b rsp_valid=%b want 0/1/0", bus_req, req_ready, rsp_valid); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstbus_no_rsp: rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic        wr, mis, err;
        mem_size_e   sz;
        logic [31:0] addr, wd, rd;
        logic [W-1:0] exp;
        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = mem_size_e'(3'($urandom_range(0, 4)));
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            mis  = m_mis(sz, addr[1:0]);
            send(wr, sz, addr, wd);
            if (mis) begin
                exp_q.push_back({1'b1, 1'b0, 32'h0});
            end else begin
                repeat ($urandom_range(0, 2)) tick();
                n_checks++;
                if (bus_req !== 1'b1 || bus_we !== wr || bus_addr !== {addr[31:2], 2'b00} ||
                    bus_wstrb !== m_strobe(wr, sz, addr[1:0]) || bus_wdata !== m_wdata(wr, sz, wd)) begin
                    n_fail++; $display("FAIL b2b_bus[%0d]: got req=%b we=%b addr=%h strb=%b wdata=%h want 1 %b %h %b %h",
                                       i, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, wr,
                                       {addr[31:2], 2'b00}, m_strobe(wr, sz, addr[1:0]), m_wdata(wr, sz, wd));
                end
                err = ($urandom_range(0, 7) == 0);
                exp_q.push_back({1'b0, err, (err || wr) ? 32'h0 : m_load(sz, addr[1:0], rd)});
                bus_rdata = rd;
                bus_ack   = 1'($urandom_range(0, 1)) | !err;
                bus_err   = err;
                tick();
                bus_ack   = 1'b0;
                bus_err   = 1'b0;
            end
            n_checks++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rsp_valid);
            end else begin
                exp = exp_q.pop_front();
                if ({rsp_misaligned, rsp_fault, rsp_rdata} !== exp) begin
                    n_fail++; $display("FAIL b2b_rsp[%0d]: got %h want %h (wr=%b sz=%0d addr=%h rd=%h)",
                                       i, {rsp_misaligned, rsp_fault, rsp_rdata}, exp, wr, sz, addr, rd); end
            end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_resp_ready[%0d]: got %b want 0", i, req_ready); end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = SIZE_B;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0;

        test_reset();
        test_load_byte_signed();
        test_store_half();
        test_misaligned();
        test_ack_err();
        test_timeout();
        test_reset_in_bus();
        test_back_to_back();

        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of bus wait cycles before a fault; it SHALL be used only when CORE_LSU_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single core clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  memory request from execute stage.
REQ-005 req_ready  output  1  LSU can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  core_pkg::mem_size_e  access size (SIZE_B, SIZE_BU, SIZE_H, SIZE_HU, SIZE_W).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  aligned, extended load data; 0 for stores and faults.
REQ-012 rsp_misaligned  output  1  request rejected as misaligned.
REQ-013 rsp_fault  output  1  bus error or timeout.
REQ-014 bus_req, bus_we  output  1 each  bus request and write enable.
REQ-015 bus_addr  output  32  word address, with bits [1:0] = 0.
REQ-016 bus_wstrb  output  4;  bus_wdata  output  32  byte strobes and lane-replicated store data.
REQ-017 bus_ack, bus_err  input  1 each;  bus_rdata  input  32  bus completion and read word.

Function
REQ-018 The FSM SHALL have states IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted when req_valid and req_ready are both 1; all request fields SHALL be registered on that edge.
REQ-020 Misalignment rules: SIZE_W is misaligned when addr[1:0] != 0; SIZE_H or SIZE_HU is misaligned when addr[0] = 1; byte accesses are never misaligned.
REQ-021 On acceptance of a misaligned request: go to RESP with rsp_misaligned = 1; bus_req SHALL never assert for that request.
REQ-022 On acceptance of an aligned request: go to BUS, where bus_req = 1 and bus_addr, bus_we, bus_wstrb and bus_wdata are held stable until the cycle of ack, err or timeout.
REQ-023 bus_wstrb SHALL be: byte = 4'b0001 << off; half = 4'b0011 << off; word = 4'b1111. bus_wstrb SHALL be 0 for loads.
REQ-024 bus_wdata SHALL be the byte replicated x4, the half replicated x2, or the full word.
REQ-025 In BUS, bus_ack SHALL capture the loaded data and move to RESP; bus_err SHALL set rsp_fault and move to RESP; if ack and err arrive in the same cycle, err SHALL win.
REQ-026 Load data SHALL be extracted at offset off; SIZE_B and SIZE_H sign-extend, SIZE_BU and SIZE_HU zero-extend.
REQ-027 RESP SHALL last exactly one cycle with rsp_valid = 1, then return to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-028 Latency: for acceptance at cycle N with ack at the first bus_req cycle N+1, rsp_valid SHALL assert at N+2; for a misaligned request, rsp_valid SHALL assert at N+1.
REQ-029 bus_ack and bus_err SHALL be ignored outside BUS.
REQ-030 rsp_* outputs SHALL be 0 whenever rsp_valid = 0.

Reset
REQ-031 With rst = 1, the next state SHALL be IDLE and all outputs 0 except req_ready = 1; the timeout counter SHALL be cleared.
REQ-032 A reset during BUS SHALL drop bus_req on the next edge, and no rsp_valid SHALL be produced for the aborted request.

Configuration
REQ-033 With CORE_LSU_TIMEOUT_EN defined, a counter SHALL clear on BUS entry and increment each BUS cycle without ack or err.
REQ-034 When the counter reaches TIMEOUT_CYCLES, the LSU SHALL set rsp_fault, drop bus_req and move to RESP.
REQ-035 Without CORE_LSU_TIMEOUT_EN, no counter SHALL exist and BUS SHALL wait indefinitely.

Structure
REQ-036 core_pkg SHALL hold mem_size_e and the lsu_state_e enum (IDLE, BUS, RESP).
REQ-037 One sub-module, core_lsu_align, SHALL be combinational and map (size, offset, bus_rdata) to extended load data.

Verification
REQ-038 LB at addr 0x103 with bus_rdata 0x80FF_FF00 and ack on the first cycle -> bus_addr 0x100, rsp_rdata 0xFFFF_FF80, rsp_valid at N+2.
REQ-039 SH at 0x202 with wdata 0x0000_BEEF -> bus_wstrb 4'b1100, bus_wdata 0xBEEF_BEEF, bus_we = 1.
REQ-040 LW at 0x301 -> rsp_misaligned = 1 at N+1 and bus_req never asserted.
REQ-041 LHU at 0x400 with ack and err in the same cycle -> rsp_fault = 1, rsp_rdata 0.
REQ-042 With CORE_LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> bus_req drops after 4 BUS cycles, then rsp_fault = 1.
REQ-043 rst asserted in the second BUS cycle -> bus_req = 0 and req_ready = 1 next cycle, with no rsp_valid.
